// File: rtl/atm_account_bank.sv
// atm_account_bank: account register-file (balance, PIN, lock bit) plus a
// per-session PIN authenticator feeding the ATM control FSM. Next-state and
// output decode is combinational; every output is taken from a register.
module atm_account_bank #(
  parameter int balance_width = 20,
  parameter int acct_width    = 3,
  parameter int pin_width     = 16,
  parameter int max_tries     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_in,
  input  logic [acct_width-1:0]    acct_id,
  input  logic                     pin_valid,
  input  logic [pin_width-1:0]     pin,
  input  logic                     op_done,
  input  logic                     error,
  input  logic [balance_width-1:0] balance,
  input  logic                     prog_en,
  input  logic [acct_width-1:0]    prog_acct,
  input  logic [pin_width-1:0]     prog_pin,
  input  logic [balance_width-1:0] prog_balance,
  output logic [balance_width-1:0] current_balance,
  output logic                     wrong_psw,
  output logic                     pin_bad,
  output logic                     locked,
  output logic                     busy
);

  localparam int         NACCT = 2 ** acct_width;
  localparam logic [2:0] MAX_T = 3'(max_tries);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_AUTH, S_LOCK} state_t;

  // account store
  logic [balance_width-1:0] bal_q  [NACCT];
  logic [pin_width-1:0]     pin_q  [NACCT];
  logic [NACCT-1:0]         lock_q;

  // session state
  state_t                   state_q, state_d;
  logic [acct_width-1:0]    acct_q, acct_d;
  logic [2:0]               tries_q, tries_d;
  logic                     card_prev_q;
  logic                     wr_bal, wr_lock;

  // registered outputs
  logic [balance_width-1:0] cur_bal_q, cur_bal_d;
  logic                     wrong_q, wrong_d;
  logic                     pin_bad_q, pin_bad_d;
  logic                     locked_q, locked_d;
  logic                     busy_q, busy_d;

  // Session FSM decode; outputs are derived from the next state so they
  // line up with the state register one edge after the triggering input.
  always_comb begin
    state_d   = state_q;
    acct_d    = acct_q;
    tries_d   = tries_q;
    wr_bal    = 1'b0;
    wr_lock   = 1'b0;
    pin_bad_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (card_in && !card_prev_q) begin
          acct_d  = acct_id;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tries_d = '0;
        if (!card_in)              state_d = S_IDLE;
        else if (lock_q[acct_q])   state_d = S_LOCK;
        else                       state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!card_in) begin
          state_d = S_IDLE;
          tries_d = '0;
        end else if (pin_valid) begin
          if (pin == pin_q[acct_q]) begin
            state_d = S_AUTH;
          end else begin
            pin_bad_d = 1'b1;
            tries_d   = tries_q + 3'd1;
            if (tries_q + 3'd1 == MAX_T) begin
              wr_lock = 1'b1;
              state_d = S_LOCK;
            end
          end
        end
      end
      S_AUTH: begin
        // a commit coinciding with card removal still lands
        wr_bal = op_done && !error;
        if (!card_in) begin
          state_d = S_IDLE;
          tries_d = '0;
        end
      end
      S_LOCK: begin
        if (!card_in) begin
          state_d = S_IDLE;
          tries_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    wrong_d   = (state_d != S_AUTH);
    locked_d  = (state_d == S_LOCK);
    cur_bal_d = '0;
    if (state_d == S_AUTH)
      cur_bal_d = wr_bal ? balance : bal_q[acct_q];
  end

  // State, account store and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      acct_q      <= '0;
      tries_q     <= '0;
      card_prev_q <= 1'b0;
      lock_q      <= '0;
      for (int i = 0; i < NACCT; i++) begin
        bal_q[i] <= '0;
        pin_q[i] <= '0;
      end
      cur_bal_q   <= '0;
      wrong_q     <= 1'b1;
      pin_bad_q   <= 1'b0;
      locked_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acct_q      <= acct_d;
      tries_q     <= tries_d;
      card_prev_q <= card_in;
      // admin programming only while no session is open
      if (state_q == S_IDLE && prog_en) begin
        pin_q[prog_acct]  <= prog_pin;
        bal_q[prog_acct]  <= prog_balance;
        lock_q[prog_acct] <= 1'b0;
      end
      if (wr_bal)  bal_q[acct_q]  <= balance;
      if (wr_lock) lock_q[acct_q] <= 1'b1;
      cur_bal_q   <= cur_bal_d;
      wrong_q     <= wrong_d;
      pin_bad_q   <= pin_bad_d;
      locked_q    <= locked_d;
      busy_q      <= busy_d;
    end
  end

  assign current_balance = cur_bal_q;
  assign wrong_psw       = wrong_q;
  assign pin_bad         = pin_bad_q;
  assign locked          = locked_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_atm_account_bank.sv
// Self-checking bench for atm_account_bank: per-cycle vectors with expected
// outputs after the edge, routed through a scoreboard queue.
module tb_atm_account_bank;

  logic        clk = 1'b0;
  logic        rst, card_in, pin_valid, op_done, error, prog_en;
  logic [2:0]  acct_id, prog_acct;
  logic [15:0] pin, prog_pin;
  logic [19:0] balance, prog_balance, current_balance;
  logic        wrong_psw, pin_bad, locked, busy;

  always #5 clk = ~clk;

  atm_account_bank dut (
    .clk(clk), .rst(rst), .card_in(card_in), .acct_id(acct_id),
    .pin_valid(pin_valid), .pin(pin), .op_done(op_done), .error(error),
    .balance(balance), .prog_en(prog_en), .prog_acct(prog_acct),
    .prog_pin(prog_pin), .prog_balance(prog_balance),
    .current_balance(current_balance), .wrong_psw(wrong_psw),
    .pin_bad(pin_bad), .locked(locked), .busy(busy)
  );

  typedef struct packed {
    logic rst; logic card; logic [2:0] id; logic pv; logic [15:0] pin;
    logic od; logic er; logic [19:0] bal;
    logic pe; logic [2:0] pa; logic [15:0] pp; logic [19:0] pb;
  } in_t;
  typedef struct packed {
    logic [19:0] cb; logic wp; logic pbad; logic lk; logic by;
  } out_t;
  typedef struct { string nm; in_t i; out_t e; } vec_t;

  vec_t  tbl[$];
  out_t  exp_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic in_t base(logic card);
    in_t x = '0;
    x.rst = 1'b1; x.card = card;
    return x;
  endfunction
  function automatic in_t ins(logic [2:0] a);
    in_t x = base(1'b1); x.id = a; return x;
  endfunction
  function automatic in_t pin_in(logic card, logic [15:0] p);
    in_t x = base(card); x.pv = 1'b1; x.pin = p; return x;
  endfunction
  function automatic in_t done(logic card, logic [19:0] b, logic e);
    in_t x = base(card); x.od = 1'b1; x.er = e; x.bal = b; return x;
  endfunction
  function automatic in_t prog(logic card, logic [2:0] a, logic [15:0] p, logic [19:0] b);
    in_t x = base(card); x.pe = 1'b1; x.pa = a; x.pp = p; x.pb = b; return x;
  endfunction
  function automatic in_t rst_in();
    in_t x = base(1'b0); x.rst = 1'b0; return x;
  endfunction

  function automatic out_t O(logic [19:0] cb, logic wp, logic pb, logic lk, logic by);
    out_t o; o.cb = cb; o.wp = wp; o.pbad = pb; o.lk = lk; o.by = by; return o;
  endfunction
  function automatic out_t o_idle();           return O(20'd0, 1, 0, 0, 0); endfunction
  function automatic out_t o_wait();           return O(20'd0, 1, 0, 0, 1); endfunction
  function automatic out_t o_bad();            return O(20'd0, 1, 1, 0, 1); endfunction
  function automatic out_t o_lock();           return O(20'd0, 1, 0, 1, 1); endfunction
  function automatic out_t o_lockbad();        return O(20'd0, 1, 1, 1, 1); endfunction
  function automatic out_t o_auth(logic [19:0] b); return O(b, 0, 0, 0, 1); endfunction

  task automatic add(string nm, in_t i, out_t e);
    vec_t v; v.nm = nm; v.i = i; v.e = e; tbl.push_back(v);
  endtask

  // drive one cycle, queue its expectation, compare after the edge
  task automatic step(vec_t v);
    out_t got, ex;
    string nm;
    @(negedge clk);
    rst = v.i.rst; card_in = v.i.card; acct_id = v.i.id;
    pin_valid = v.i.pv; pin = v.i.pin; op_done = v.i.od; error = v.i.er;
    balance = v.i.bal; prog_en = v.i.pe; prog_acct = v.i.pa;
    prog_pin = v.i.pp; prog_balance = v.i.pb;
    exp_q.push_back(v.e); nm_q.push_back(v.nm);
    @(posedge clk); #1;
    got = O(current_balance, wrong_psw, pin_bad, locked, busy);
    ex = exp_q.pop_front(); nm = nm_q.pop_front();
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL %s: got cb=%0d wp=%b pb=%b lk=%b busy=%b, want cb=%0d wp=%b pb=%b lk=%b busy=%b",
               nm, got.cb, got.wp, got.pbad, got.lk, got.by,
               ex.cb, ex.wp, ex.pbad, ex.lk, ex.by);
    end
  endtask

  task automatic run(string nm, in_t i, out_t e);
    vec_t v; v.nm = nm; v.i = i; v.e = e; step(v);
  endtask

  initial begin
    // main flow table
    add("reset",          rst_in(),                          o_idle());
    add("idle",           base(0),                           o_idle());
    add("prog2",          prog(0, 3'd2, 16'h1234, 20'd500),  o_idle());
    add("ins_load",       ins(3'd2),                         o_wait());
    add("wait_pin",       base(1),                           o_wait());
    add("pin_ok",         pin_in(1, 16'h1234),               o_auth(20'd500));
    add("auth_hold",      base(1),                           o_auth(20'd500));
    add("commit300",      done(1, 20'd300, 0),               o_auth(20'd300));
    add("err_nocommit",   done(1, 20'd0, 1),                 o_auth(20'd300));
    add("auth_pin_ign",   pin_in(1, 16'h0bad),               o_auth(20'd300));
    add("remove1",        base(0),                           o_idle());
    // three wrong PINs lock the account
    add("ins2",           ins(3'd2),                         o_wait());
    add("wait2",          base(1),                           o_wait());
    add("bad1",           pin_in(1, 16'h1111),               o_bad());
    add("bad1_gap",       base(1),                           o_wait());
    add("bad2",           pin_in(1, 16'h2222),               o_bad());
    add("bad3_lock",      pin_in(1, 16'h3333),               o_lockbad());
    add("locked_hold",    base(1),                           o_lock());
    add("locked_pin_ign", pin_in(1, 16'h1234),               o_lock());
    add("remove2",        base(0),                           o_idle());
    add("reins_load",     ins(3'd2),                         o_wait());
    add("reins_locked",   base(1),                           o_lock());
    add("reins_pin_ign",  pin_in(1, 16'h1234),               o_lock());
    add("remove3",        base(0),                           o_idle());
    add("reprog_unlock",  prog(0, 3'd2, 16'h1234, 20'd300),  o_idle());
    add("ins3",           ins(3'd2),                         o_wait());
    add("wait3",          base(1),                           o_wait());
    add("pin_ok3",        pin_in(1, 16'h1234),               o_auth(20'd300));
    add("remove4",        base(0),                           o_idle());
    // retry counter is per session
    add("ins4",           ins(3'd2),                         o_wait());
    add("wait4",          base(1),                           o_wait());
    add("s1_bad1",        pin_in(1, 16'h0001),               o_bad());
    add("s1_bad2",        pin_in(1, 16'h0002),               o_bad());
    add("remove5",        base(0),                           o_idle());
    add("ins5",           ins(3'd2),                         o_wait());
    add("wait5",          base(1),                           o_wait());
    add("s2_bad1",        pin_in(1, 16'h0003),               o_bad());
    add("s2_pin_ok",      pin_in(1, 16'h1234),               o_auth(20'd300));
    // commit coinciding with card removal
    add("drop_commit",    done(0, 20'd777, 0),               o_idle());
    add("ins6",           ins(3'd2),                         o_wait());
    add("wait6",          base(1),                           o_wait());
    add("pin_ok6",        pin_in(1, 16'h1234),               o_auth(20'd777));

    rst = 1'b0; card_in = 1'b0; acct_id = '0; pin_valid = 1'b0; pin = '0;
    op_done = 1'b0; error = 1'b0; balance = '0; prog_en = 1'b0;
    prog_acct = '0; prog_pin = '0; prog_balance = '0;

    foreach (tbl[k]) step(tbl[k]);

    // prog_en outside IDLE is ignored
    run("prog_in_auth",   prog(1, 3'd2, 16'h9999, 20'd5),    o_auth(20'd777));
    run("remove7",        base(0),                           o_idle());
    run("ins7",           ins(3'd2),                         o_wait());
    run("wait7",          base(1),                           o_wait());
    run("old_pin_kept",   pin_in(1, 16'h1234),               o_auth(20'd777));
    run("remove8",        base(0),                           o_idle());

    // pin_valid together with card removal is ignored
    run("ins8",           ins(3'd2),                         o_wait());
    run("wait8",          base(1),                           o_wait());
    run("pin_on_remove",  pin_in(0, 16'h1234),               o_idle());

    // program write coinciding with card rise on the same account
    begin
      in_t x = prog(1, 3'd3, 16'h0042, 20'd55);
      x.id = 3'd3;
      run("prog_on_rise", x,                                 o_wait());
    end
    run("wait9",          base(1),                           o_wait());
    run("pin_ok_acct3",   pin_in(1, 16'h0042),               o_auth(20'd55));

    // reset mid-session aborts and clears the store
    run("mid_reset",      rst_in(),                          o_idle());
    run("post_rst_idle",  base(0),                           o_idle());
    run("ins10",          ins(3'd2),                         o_wait());
    run("wait10",         base(1),                           o_wait());
    run("old_pin_gone",   pin_in(1, 16'h1234),               o_bad());
    run("zero_pin_ok",    pin_in(1, 16'h0000),               o_auth(20'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/atm_account_bank.md
# atm_account_bank

Account store and PIN authenticator that sits on the bank side of the ATM control FSM. It supplies `current_balance` and `wrong_psw` to the FSM and commits the FSM's resulting `balance` back into the account on `op_done`. It holds a small register-file of accounts (balance, PIN, lock bit) and runs a per-session PIN-retry counter that locks an account after repeated failures.

## Interface
- `balance_width`, 20, width of balances; must match the ATM FSM
- `acct_width`, 3, account index width; 2**acct_width accounts
- `pin_width`, 16, PIN width
- `max_tries`, 3, wrong PINs per session before lock (1..7)

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `card_in`  in  1  card present; level
- `acct_id`  in  acct_width  account on card; sampled on card_in rise
- `pin_valid`  in  1  one-cycle strobe: `pin` is valid
- `pin`  in  pin_width  entered PIN
- `op_done`  in  1  from FSM: transaction finished
- `error`  in  1  from FSM: transaction failed, do not commit
- `balance`  in  balance_width  from FSM: new balance to commit
- `prog_en`  in  1  admin write strobe; honoured only in IDLE
- `prog_acct`  in  acct_width  admin target account
- `prog_pin`  in  pin_width  admin PIN value
- `prog_balance`  in  balance_width  admin balance value
- `current_balance`  out  balance_width  balance of session account; 0 outside AUTH
- `wrong_psw`  out  1  1 unless session authenticated
- `pin_bad`  out  1  one-cycle pulse per rejected PIN
- `locked`  out  1  session account is locked
- `busy`  out  1  session active (state != IDLE)

## Operation
- States: IDLE, LOAD, WAIT_PIN, AUTH, LOCKED.
- IDLE: on `card_in` rising edge (registered previous value 0, current 1) latch `acct_id` -> LOAD. `prog_en` writes PIN/balance of `prog_acct` and clears its lock bit; `prog_en` in any other state is ignored.
- LOAD: read account entry; lock bit set -> LOCKED, else -> WAIT_PIN; clear retry counter.
- WAIT_PIN: on `pin_valid`: match -> AUTH; mismatch -> retry counter +1, pulse `pin_bad`; if counter reaches `max_tries` -> set account lock bit, -> LOCKED.
- AUTH: `wrong_psw`=0, `current_balance` = stored balance. `op_done`=1 and `error`=0 -> write `balance` into account; stay in AUTH (another service). `op_done` with `error`=1 -> no write.
- LOCKED: `locked`=1, `wrong_psw`=1; ignores `pin_valid`.
- Any state except IDLE: `card_in`=0 -> IDLE, counter cleared. If `op_done` & !`error` coincide with card removal in AUTH, the write still commits.
- Balances stored verbatim, no saturation/wrap checks (FSM owns arithmetic); width exactly `balance_width`.

## Timing
- Reset (rst=0 at an edge): state IDLE; all balances, PINs, lock bits, counter = 0; outputs `current_balance`=0, `wrong_psw`=1, `pin_bad`=0, `locked`=0, `busy`=0. Reset mid-session aborts without writing.
- All outputs registered.
- `card_in` rise sampled at edge N -> LOAD after N, WAIT_PIN (or LOCKED) after N+1; `busy`=1 from N+1.
- `pin_valid` at edge k (match) -> `wrong_psw`=0 and `current_balance` valid from k+1.
- `pin_valid` mismatch at edge k -> `pin_bad`=1 for cycle k+1 only; lock -> `locked`=1 from k+1.
- Commit at edge m -> `current_balance` shows new value from m+1.
- `pin_valid` outside WAIT_PIN ignored; `pin_valid` in the same cycle as card removal ignored.
- `prog_en` coinciding with a card_in rise: program write performed, session still starts; if same account, LOAD sees new contents next cycle.

## Test plan
- Reset, then prog acct 2 = PIN 0x1234, balance 500; card_in rise with acct_id=2, PIN 0x1234 -> `wrong_psw`=0, `current_balance`=500 one cycle after pin_valid.
- In AUTH, op_done=1, error=0, balance=300 -> `current_balance`=300 next cycle; second op_done with error=1, balance=0 -> stays 300.
- Three wrong PINs on acct 2 -> three `pin_bad` pulses, `locked`=1 after third; remove and reinsert -> LOCKED immediately even with correct PIN; prog acct 2 -> unlocked, correct PIN authenticates.
- Two wrong PINs, remove card, reinsert, one wrong then correct -> AUTH (counter per session).
- card_in drop in same cycle as op_done (balance=777) -> `busy`=0, `current_balance`=0; re-auth shows 777.
- rst=0 during AUTH -> all outputs at reset values next cycle; balance of acct 2 reads 0 after re-program check.
